dtree_feature_loader: RTL and testbench

- Front-end stage for the combinational arrhythmia decision-tree classifier.
- Accepts one sample's features as a serial byte stream over a valid/ready handshake and assembles them into a stable parallel feature bus that drives the tree's inputs.
- Waits a fixed settle time, captures the tree's class output, and presents it downstream on a valid/ready result interface.
- Converts the purely combinational tree into a framed, flow-controlled pipeline stage.

---
 rtl/dtree_feature_loader.sv | 161 ++++++++++++++++
 tb/tb_dtree_feature_loader.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtree_feature_loader.sv
// Purpose : front-end for the combinational decision-tree classifier. Collects a
//           serial feature stream into a registered parallel bus and returns the
//           tree's class on a valid/ready result interface.
// Latency : m_valid rises SETTLE edges after the edge that accepts the final beat.
// Backpr. : s_ready=0 while settling or holding a result; the result is held until m_ready.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   s_valid/s_ready     feature beat handshake; s_data = feature, s_last = end of frame
//   feat_bus            registered features, slot k at [k*FEAT_W +: FEAT_W]
//   cls_in              class code returned by the tree (sampled at end of settle)
//   m_valid/m_ready     result handshake; m_class = captured class
//   err_frame           one-cycle pulse on a short or long frame
//   frame_cnt           number of results delivered (wraps)
module dtree_feature_loader #(
    parameter int N_FEAT = 36,
    parameter int FEAT_W = 8,
    parameter int CLS_W  = 5,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [FEAT_W-1:0]        s_data,
    input  logic                     s_last,
    output logic [N_FEAT*FEAT_W-1:0] feat_bus,
    input  logic [CLS_W-1:0]         cls_in,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [CLS_W-1:0]         m_class,
    output logic                     err_frame,
    output logic [CNT_W-1:0]         frame_cnt
);

    localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_FEAT - 1);
    localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_OUT    = 2'd3
    } state_t;

    state_t                         state_q,     state_d;
    logic [IDX_W-1:0]               idx_q,       idx_d;
    logic [N_FEAT-1:0][FEAT_W-1:0]  feat_q,      feat_d;
    logic [3:0]                     settle_q,    settle_d;
    logic [CLS_W-1:0]               m_class_q,   m_class_d;
    logic                           m_valid_q,   m_valid_d;
    logic                           err_frame_q, err_frame_d;
    logic [CNT_W-1:0]               frame_cnt_q, frame_cnt_d;

    logic beat_acc;

    // Ready is a pure state decode so it needs no reset of its own; it reads 1
    // during reset because the reset state is LOAD.
    assign s_ready  = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign beat_acc = s_valid && s_ready;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        feat_d      = feat_q;
        settle_d    = settle_q;
        m_class_d   = m_class_q;
        m_valid_d   = m_valid_q;
        frame_cnt_d = frame_cnt_q;
        err_frame_d = 1'b0;

        case (state_q)
            ST_LOAD: begin
                if (beat_acc) begin
                    // Every accepted LOAD beat lands in its slot, even the
                    // terminating beat of a malformed frame.
                    feat_d[idx_q] = s_data;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (s_last) begin
                            settle_d = SETTLE_INIT;
                            state_d  = ST_SETTLE;
                        end else begin
                            // Long frame: swallow the excess beats up to s_last.
                            err_frame_d = 1'b1;
                            state_d     = ST_DRAIN;
                        end
                    end else if (s_last) begin
                        // Short frame: restart, keep partial slots, no result.
                        idx_d       = '0;
                        err_frame_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            ST_DRAIN: begin
                if (beat_acc && s_last) begin
                    state_d = ST_LOAD;
                end
            end

            ST_SETTLE: begin
                // The counter is loaded with SETTLE on the last-beat edge, so
                // capturing when it reads 1 gives exactly SETTLE edges of settle.
                if (settle_q <= 4'd1) begin
                    settle_d  = 4'd0;
                    m_class_d = cls_in;
                    m_valid_d = 1'b1;
                    state_d   = ST_OUT;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end

            ST_OUT: begin
                if (m_ready) begin
                    m_valid_d   = 1'b0;
                    frame_cnt_d = frame_cnt_q + 1'b1;
                    state_d     = ST_LOAD;
                end
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            idx_q       <= '0;
            feat_q      <= '0;
            settle_q    <= 4'd0;
            m_class_q   <= '0;
            m_valid_q   <= 1'b0;
            err_frame_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            feat_q      <= feat_d;
            settle_q    <= settle_d;
            m_class_q   <= m_class_d;
            m_valid_q   <= m_valid_d;
            err_frame_q <= err_frame_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign feat_bus  = feat_q;
    assign m_class   = m_class_q;
    assign m_valid   = m_valid_q;
    assign err_frame = err_frame_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_dtree_feature_loader.sv
// Purpose : self-checking bench for dtree_feature_loader; instance 0 uses the
//           default parameters, instance 1 uses SETTLE=3 and CNT_W=2.
// Expected classes are queued when a frame is driven and popped at the result handshake.
module tb_dtree_feature_loader;

    localparam int NF = 36;
    localparam int FW = 8;
    localparam int CW = 5;

    logic clk = 1'b0;
    logic rst_n;

    logic             s_valid [2];
    logic             s_ready [2];
    logic [FW-1:0]    s_data  [2];
    logic             s_last  [2];
    logic [NF*FW-1:0] feat_bus[2];
    logic [CW-1:0]    cls_in  [2];
    logic             m_valid [2];
    logic             m_ready [2];
    logic [CW-1:0]    m_class [2];
    logic             err_frame[2];
    logic [15:0]      fc0;
    logic [1:0]       fc1;

    int checks = 0;
    int errors = 0;
    int exp_q0[$];
    int exp_q1[$];
    int exp_cnt0 = 0;
    int exp_cnt1 = 0;

    always #5 clk = ~clk;

    dtree_feature_loader #(.N_FEAT(NF), .FEAT_W(FW), .CLS_W(CW), .SETTLE(1), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]), .s_last(s_last[0]),
        .feat_bus(feat_bus[0]), .cls_in(cls_in[0]),
        .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_class(m_class[0]),
        .err_frame(err_frame[0]), .frame_cnt(fc0)
    );

    dtree_feature_loader #(.N_FEAT(NF), .FEAT_W(FW), .CLS_W(CW), .SETTLE(3), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]), .s_last(s_last[1]),
        .feat_bus(feat_bus[1]), .cls_in(cls_in[1]),
        .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_class(m_class[1]),
        .err_frame(err_frame[1]), .frame_cnt(fc1)
    );

    function automatic logic [FW-1:0] slot(input logic [NF*FW-1:0] b, input int k);
        return b[k*FW +: FW];
    endfunction

    function automatic int cnt_of(input int u);
        return (u == 0) ? int'(fc0) : int'(fc1);
    endfunction

    // Drives one beat and returns #1 after the edge that accepted it.
    task automatic send_beat(input int u, input logic [FW-1:0] d, input logic l);
        int n;
        @(negedge clk);
        s_valid[u] = 1'b1;
        s_data[u]  = d;
        s_last[u]  = l;
        n = 0;
        while (!s_ready[u] && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL beat_accept u%0d: s_ready=%0d after %0d cycles, required 1", u, s_ready[u], n);
        end
        @(posedge clk);
        #1;
        s_valid[u] = 1'b0;
        s_last[u]  = 1'b0;
    endtask

    // Waits for a result, holds m_ready low for 'hold' cycles, then completes
    // one handshake and scores it against the queue.
    task automatic get_result(input int u, input int hold);
        int n;
        int exp_cls;
        int exp_cnt;
        logic [CW-1:0] cls0;
        n = 0;
        while (!m_valid[u] && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL result_wait u%0d: m_valid=%0d after %0d cycles, required 1", u, m_valid[u], n);
        end
        cls0 = m_class[u];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if (m_valid[u] !== 1'b1 || m_class[u] !== cls0 || s_ready[u] !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold u%0d cyc%0d: m_valid=%0d m_class=%0d s_ready=%0d, required 1/%0d/0",
                         u, i, m_valid[u], m_class[u], s_ready[u], cls0);
            end
        end
        m_ready[u] = 1'b1;
        @(posedge clk);
        #1;
        m_ready[u] = 1'b0;
        if (u == 0) begin
            exp_cls  = (exp_q0.size() > 0) ? exp_q0.pop_front() : -1;
            exp_cnt0 = (exp_cnt0 + 1) % 65536;
            exp_cnt  = exp_cnt0;
        end else begin
            exp_cls  = (exp_q1.size() > 0) ? exp_q1.pop_front() : -1;
            exp_cnt1 = (exp_cnt1 + 1) % 4;
            exp_cnt  = exp_cnt1;
        end
        checks++;
        if (int'(cls0) !== exp_cls) begin
            errors++;
            $display("FAIL result_class u%0d: got %0d, required %0d", u, cls0, exp_cls);
        end
        checks++;
        if (cnt_of(u) !== exp_cnt) begin
            errors++;
            $display("FAIL frame_cnt u%0d: got %0d, required %0d", u, cnt_of(u), exp_cnt);
        end
        checks++;
        if (m_valid[u] !== 1'b0 || s_ready[u] !== 1'b1) begin
            errors++;
            $display("FAIL post_handshake u%0d: m_valid=%0d s_ready=%0d, required 0/1", u, m_valid[u], s_ready[u]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            s_valid[u] = 1'b0; s_data[u] = '0; s_last[u] = 1'b0;
            cls_in[u] = '0; m_ready[u] = 1'b0;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (m_valid[0] !== 1'b0 || err_frame[0] !== 1'b0 || feat_bus[0] !== '0 || fc0 !== 16'd0 || m_class[0] !== '0) begin
            errors++;
            $display("FAIL reset_state: m_valid=%0d err=%0d feat=%h cnt=%0d cls=%0d, required all 0",
                     m_valid[0], err_frame[0], feat_bus[0], fc0, m_class[0]);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (s_ready[0] !== 1'b1 || s_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: s_ready=%0d/%0d, required 1/1", s_ready[0], s_ready[1]);
        end
    endtask

    task automatic test_nominal();
        cls_in[0] = 5'd14;
        exp_q0.push_back(14);
        for (int k = 0; k < NF; k++) send_beat(0, FW'(k + 1), k == NF - 1);
        checks++;
        if (slot(feat_bus[0], 0) !== 8'd1 || slot(feat_bus[0], 35) !== 8'd36 || m_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL nominal_bus: slot0=%0d slot35=%0d m_valid=%0d, required 1/36/0",
                     slot(feat_bus[0], 0), slot(feat_bus[0], 35), m_valid[0]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (m_valid[0] !== 1'b1 || m_class[0] !== 5'd14) begin
            errors++;
            $display("FAIL nominal_latency: m_valid=%0d m_class=%0d, required 1/14", m_valid[0], m_class[0]);
        end
        get_result(0, 0);
    endtask

    task automatic test_backpressure();
        cls_in[0] = 5'd21;
        exp_q0.push_back(21);
        for (int k = 0; k < NF; k++) send_beat(0, FW'(k + 50), k == NF - 1);
        // Keep a beat offered the whole time the result is blocked.
        s_valid[0] = 1'b1;
        s_data[0]  = 8'hAA;
        s_last[0]  = 1'b0;
        get_result(0, 10);
        s_valid[0] = 1'b0;
        checks++;
        if (slot(feat_bus[0], 0) !== 8'd50 || slot(feat_bus[0], 35) !== 8'd85) begin
            errors++;
            $display("FAIL bp_no_accept: slot0=%0d slot35=%0d, required 50/85",
                     slot(feat_bus[0], 0), slot(feat_bus[0], 35));
        end
    endtask

    task automatic test_short_frame();
        cls_in[0] = 5'd2;
        for (int k = 0; k <= 10; k++) send_beat(0, FW'(100 + k), k == 10);
        checks++;
        if (err_frame[0] !== 1'b1 || slot(feat_bus[0], 10) !== 8'd110 || slot(feat_bus[0], 11) !== 8'd61) begin
            errors++;
            $display("FAIL short_err: err=%0d slot10=%0d slot11=%0d, required 1/110/61",
                     err_frame[0], slot(feat_bus[0], 10), slot(feat_bus[0], 11));
        end
        @(posedge clk);
        #1;
        checks++;
        if (err_frame[0] !== 1'b0 || m_valid[0] !== 1'b0 || s_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL short_after: err=%0d m_valid=%0d s_ready=%0d, required 0/0/1",
                     err_frame[0], m_valid[0], s_ready[0]);
        end
        cls_in[0] = 5'd9;
        exp_q0.push_back(9);
        for (int k = 0; k < NF; k++) send_beat(0, FW'(k + 7), k == NF - 1);
        checks++;
        if (slot(feat_bus[0], 0) !== 8'd7 || slot(feat_bus[0], 35) !== 8'd42) begin
            errors++;
            $display("FAIL short_recover_bus: slot0=%0d slot35=%0d, required 7/42",
                     slot(feat_bus[0], 0), slot(feat_bus[0], 35));
        end
        get_result(0, 0);
    endtask

    task automatic test_long_frame();
        cls_in[0] = 5'd30;
        for (int k = 0; k < 40; k++) begin
            send_beat(0, FW'(200 + k), k == 39);
            if (k == 35) begin
                checks++;
                if (err_frame[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL long_err: err=%0d after beat 35, required 1", err_frame[0]);
                end
            end
            if (k == 36) begin
                checks++;
                if (err_frame[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL long_err_pulse: err=%0d after beat 36, required 0", err_frame[0]);
                end
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (slot(feat_bus[0], 0) !== 8'd200 || slot(feat_bus[0], 35) !== 8'd235 ||
            m_valid[0] !== 1'b0 || s_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL long_bus: slot0=%0d slot35=%0d m_valid=%0d s_ready=%0d, required 200/235/0/1",
                     slot(feat_bus[0], 0), slot(feat_bus[0], 35), m_valid[0], s_ready[0]);
        end
    endtask

    task automatic test_settle_latency();
        cls_in[1] = 5'd3;
        exp_q1.push_back(7);
        for (int k = 0; k < NF; k++) send_beat(1, FW'(k), k == NF - 1);
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (m_valid[1] !== (e == 3)) begin
                errors++;
                $display("FAIL settle_edge%0d: m_valid=%0d, required %0d", e, m_valid[1], e == 3);
            end
            if (e == 2) cls_in[1] = 5'd7;
        end
        get_result(1, 0);
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k <= 20; k++) send_beat(0, FW'(30 + k), 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        checks++;
        if (m_valid[0] !== 1'b0 || feat_bus[0] !== '0 || fc0 !== 16'd0 || fc1 !== 2'd0 || s_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_midframe: m_valid=%0d feat=%h cnt0=%0d cnt1=%0d s_ready=%0d, required 0/0/0/0/1",
                     m_valid[0], feat_bus[0], fc0, fc1, s_ready[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cls_in[0] = 5'd17;
        for (int k = 0; k < NF; k++) send_beat(0, FW'(60 + k), k == NF - 1);
        @(posedge clk);
        #1;
        checks++;
        if (m_valid[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_out_pre: m_valid=%0d, required 1", m_valid[0]);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_valid[0] !== 1'b0 || feat_bus[0] !== '0 || fc0 !== 16'd0) begin
            errors++;
            $display("FAIL reset_in_out: m_valid=%0d feat=%h cnt=%0d, required 0/0/0", m_valid[0], feat_bus[0], fc0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_beat(0, 8'h5A, 1'b0);
        checks++;
        if (slot(feat_bus[0], 0) !== 8'h5A || slot(feat_bus[0], 1) !== 8'h00 || m_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_restart: slot0=%h slot1=%h m_valid=%0d, required 5a/00/0",
                     slot(feat_bus[0], 0), slot(feat_bus[0], 1), m_valid[0]);
        end
    endtask

    task automatic test_counter_wrap();
        for (int f = 0; f < 5; f++) begin
            cls_in[1] = CW'(f + 1);
            exp_q1.push_back(f + 1);
            for (int k = 0; k < NF; k++) send_beat(1, FW'(f * 3 + k), k == NF - 1);
            get_result(1, 0);
        end
        checks++;
        if (fc1 !== 2'd1) begin
            errors++;
            $display("FAIL counter_wrap: frame_cnt=%0d, required 1", fc1);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_short_frame();
        test_long_frame();
        test_settle_latency();
        test_reset_mid();
        test_counter_wrap();
        checks++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d/%0d results never delivered, required 0/0",
                     exp_q0.size(), exp_q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
